// File: rtl/fifo_rr_ingress_ctrl.sv
// Round-robin merge of NUM_SRC val/rdy producers into one buffered val/rdy stream.
// Define FIFO_ARB_PKT_LOCK_EN to hold the grant for a whole packet (up to src_last).

module fifo_1r1w #(
    parameter int unsigned width_p    = 8,
    parameter int unsigned log2_els_p = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_req,
    input  logic [width_p-1:0] wr_data,
    input  logic               rd_req,
    output logic [width_p-1:0] rd_data,
    output logic               full,
    output logic               empty
);
    localparam int unsigned ELS   = 1 << log2_els_p;
    localparam int unsigned PTR_W = log2_els_p + 1;

    logic [width_p-1:0] mem [ELS];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Pointers carry one extra wrap bit so full and empty stay distinct.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_req) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_req) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_req) mem[wr_ptr[log2_els_p-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[log2_els_p-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[log2_els_p] != rd_ptr[log2_els_p]) &&
                     (wr_ptr[log2_els_p-1:0] == rd_ptr[log2_els_p-1:0]);
endmodule

module fifo_rr_ingress_ctrl #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned LOG2_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC-1:0]          src_val,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    input  logic [NUM_SRC-1:0]          src_last,
    output logic [NUM_SRC-1:0]          src_rdy,
    output logic                        dst_val,
    output logic [DATA_W-1:0]           dst_data,
    output logic                        dst_last,
    output logic [$clog2(NUM_SRC)-1:0]  dst_src_id,
    input  logic                        dst_rdy
);
    localparam int unsigned ID_W    = $clog2(NUM_SRC);
    localparam int unsigned ENTRY_W = DATA_W + 1 + ID_W;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t          wr_entry;
    entry_t          rd_entry;
    logic            full;
    logic            empty;
    logic            wr_req;
    logic            rd_req;
    logic            guard;
    logic            accept;
    logic            grant_ok;
    logic            sel_last;
    logic            cand_found;
    logic [ID_W-1:0] cand_id;
    logic [ID_W-1:0] sel_id;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rr_ptr_nxt;

`ifdef FIFO_ARB_PKT_LOCK_EN
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] grant_id_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= '0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_id_nxt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) rr_ptr <= '0;
        else     rr_ptr <= rr_ptr_nxt;
    end

    // First valid source scanning cyclically from rr_ptr.
    always_comb begin
        cand_found = 1'b0;
        cand_id    = rr_ptr;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!cand_found && src_val[rr_ptr + ID_W'(k)]) begin
                cand_found = 1'b1;
                cand_id    = rr_ptr + ID_W'(k);
            end
        end
    end

    always_comb begin
        rr_ptr_nxt = rr_ptr;
        sel_id     = cand_id;
        grant_ok   = cand_found;
`ifdef FIFO_ARB_PKT_LOCK_EN
        state_nxt    = state;
        grant_id_nxt = grant_id;
        if (state == LOCK) begin
            sel_id   = grant_id;
            grant_ok = 1'b1;
        end
`endif
        accept   = grant_ok && !full && !rst && src_val[sel_id];
        sel_last = src_last[sel_id];
`ifdef FIFO_ARB_PKT_LOCK_EN
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sel_last) begin
                        rr_ptr_nxt = sel_id + ID_W'(1);
                    end else begin
                        state_nxt    = LOCK;
                        grant_id_nxt = sel_id;
                    end
                end
            end
            LOCK: begin
                if (accept && sel_last) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = grant_id + ID_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
`else
        if (accept) rr_ptr_nxt = sel_id + ID_W'(1);
`endif
    end

    always_comb begin
        src_rdy         = '0;
        src_rdy[sel_id] = grant_ok && !full && !rst;
    end

    assign wr_req        = accept;
    assign wr_entry.id   = sel_id;
    assign wr_entry.last = sel_last;
    assign wr_entry.data = src_data[DATA_W*32'(sel_id) +: DATA_W];

    // Hides the entry for one cycle after a write into an empty FIFO.
    always_ff @(posedge clk) begin
        if (rst) guard <= 1'b0;
        else     guard <= wr_req && empty;
    end

    assign dst_val    = !empty && !guard && !rst;
    assign rd_req     = dst_val && dst_rdy;
    assign dst_data   = rd_entry.data;
    assign dst_last   = rd_entry.last;
    assign dst_src_id = rd_entry.id;

    fifo_1r1w #(
        .width_p    (ENTRY_W),
        .log2_els_p (LOG2_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_req  (wr_req),
        .wr_data (wr_entry),
        .rd_req  (rd_req),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty)
    );
endmodule

// File: doc/fifo_rr_ingress_ctrl.md
Name: fifo_rr_ingress_ctrl

Overview:
- Shares the write port of one internal fifo_1r1w among NUM_SRC independent val/rdy producers, using packet-atomic round-robin arbitration.
- Presents the drained FIFO as a single val/rdy stream. Each beat carries its source id and last flag.
- Sits in front of the encoder datapath wherever several streams must be merged into one buffered stream.

Parameters:
- NUM_SRC, 4, number of requesters; power of two, 2..16.
- DATA_W, 64, payload width per beat.
- LOG2_DEPTH, 4, log2 of FIFO depth; this is passed to fifo_1r1w as log2_els_p.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- src_val  in  NUM_SRC  per-source beat valid
- src_data  in  NUM_SRC*DATA_W  per-source payload; source i occupies bits [i*DATA_W +: DATA_W]
- src_last  in  NUM_SRC  per-source end-of-packet flag
- src_rdy  out  NUM_SRC  per-source accept
- dst_val  out  1  output beat valid
- dst_data  out  DATA_W  output payload
- dst_last  out  1  output end-of-packet flag
- dst_src_id  out  $clog2(NUM_SRC)  id of the source that produced the beat
- dst_rdy  in  1  consumer accept

Behaviour:
- Instantiates fifo_1r1w with width_p = DATA_W + 1 + $clog2(NUM_SRC). Each entry packs {src_id, last, data}.
- The FIFO has no internal overflow or underflow protection. This block must never assert wr_req when full and never assert rd_req when empty.
- Arbiter FSM states:
  - IDLE: no packet in progress.
  - LOCK: grant held by grant_id.
- In IDLE:
  - Candidate = first i with src_val[i]=1, scanning cyclically from rr_ptr.
  - src_rdy[candidate] = !full; all other src_rdy are 0.
  - On an accepted beat (val&rdy) with last=0: go to LOCK and set grant_id = candidate.
  - On an accepted beat with last=1: stay in IDLE and set rr_ptr = candidate+1 mod NUM_SRC.
- In LOCK:
  - src_rdy[grant_id] = !full; all other src_rdy are 0.
  - On an accepted beat with last=1: go to IDLE and set rr_ptr = grant_id+1 mod NUM_SRC.
  - Other sources stall for the whole packet, even when grant_id is idle (src_val=0).
- src_rdy depends combinationally on src_val in IDLE. Producers must not make src_val depend on src_rdy.
- Write rules:
  - wr_req = any accepted beat; at most one per cycle.
  - Writes are gated by the FIFO full flag only. A same-cycle read does not free a slot for a write in that cycle.
- Read side:
  - rd_req = dst_val & dst_rdy.
  - dst_val = !empty & !guard. guard is a 1-cycle register, set when a write occurs while count==0 (count = FIFO occupancy). It covers RAM read-during-write returning stale data.
  - Minimum latency from src accept at cycle t to dst_val is t+2.
  - Once dst_val=1, dst_data, dst_last and dst_src_id hold stable until accepted.
- Wrap-around: FIFO pointers carry an extra wrap bit. Full and empty stay correct across any number of wraps.
- Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0, guard=0.
  - src_rdy=0 and dst_val=0 during the reset cycle; dst_data is don't-care.
  - Reset mid-packet discards the FIFO contents and any partial packet without emitting it. The first post-reset grant starts from source 0.
- Simultaneous events: a read and a write in the same cycle leave occupancy unchanged. At count==1 the guard does not trigger; the next entry's data comes from an address written at least one cycle earlier.

Optional Feature:
- FIFO_ARB_PKT_LOCK_EN.
- Defined: packet-atomic arbitration as described above, with the LOCK state.
- Undefined:
  - The LOCK state is not synthesized and src_last is treated as 1 for arbitration only, so round-robin advances after every accepted beat.
  - src_last is still stored in the FIFO and forwarded on dst_last.
  - Beats from different sources may interleave at dst.

Test Plan:
- Single source 0 sends 1 beat 0xA5 (last=1) with dst_rdy=1 -> dst_val rises exactly 2 cycles after accept; dst_data=0xA5, dst_src_id=0, dst_last=1.
- All 4 sources continuously valid with 1-beat packets and dst_rdy=1 -> grant order 0,1,2,3,0,...; each id appears once per 4 consecutive output beats.
- Macro defined; src1 sends a 3-beat packet while src2 stays valid -> src2 rdy=0 until src1's last beat is accepted, then src2 is granted; the 3 beats are contiguous at dst.
- dst_rdy=0 and source 0 streams 20 beats with LOG2_DEPTH=4 -> exactly 16 accepted, src_rdy[0]=0 afterwards; dst_rdy=1 -> 16 beats drain in order, then the remaining 4 flow.
- Fill/drain through 3 full pointer wraps (48+ beats, random dst_rdy) -> no loss, duplication or reordering per source; full and empty never both 1.
- Assert rst mid-packet with 5 entries queued -> dst_val=0 the cycle after reset; no stale beats emitted; the next grant goes to source 0.
